// File: rtl/sd_1011_scan_ctrl.sv
// Two-requester round-robin scan controller: a granted word is shifted MSB-first
// through an overlapping "1011" Mealy detector and its match count is returned.
module sd_1011_scan_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          req0,
    input  logic [W-1:0]  data0,
    input  logic          req1,
    input  logic [W-1:0]  data1,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          ser_x,
    output logic [1:0]    det_state,
    output logic          done,
    output logic          done_id,
    output logic [CW-1:0] match_cnt
);
    localparam int BW = $clog2(W);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  shreg;
    logic [BW-1:0] bitcnt;
    logic [CW-1:0] run_cnt, cnt_nxt;
    logic [1:0]    det, det_nxt;
    logic          last_id;
    logic          any_req, win, hit, last_bit;

    // Tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        any_req  = req0 | req1;
        win      = (req0 & req1) ? ~last_id : req1;
        last_bit = (bitcnt == BW'(W-1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ser_x   = (state == SHIFT) ? shreg[W-1] : 1'b0;
        det_nxt = S0;
        hit     = 1'b0;
        case (det)
            S0: det_nxt = ser_x ? S1 : S0;
            S1: det_nxt = ser_x ? S1 : S2;
            S2: det_nxt = ser_x ? S3 : S0;
            S3: begin
                det_nxt = ser_x ? S1 : S2;
                hit     = ser_x;
            end
            default: det_nxt = S0;
        endcase
        cnt_nxt = (hit && run_cnt != '1) ? run_cnt + CW'(1) : run_cnt;
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        det_state = det;
    end

    always_ff @(posedge clk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            grant     <= 2'b00;
            shreg     <= '0;
            bitcnt    <= '0;
            run_cnt   <= '0;
            det       <= S0;
            last_id   <= 1'b1;
            done_id   <= 1'b0;
            match_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    grant   <= win ? 2'b10 : 2'b01;
                    last_id <= win;
                    shreg   <= win ? data1 : data0;
                    bitcnt  <= '0;
                    run_cnt <= '0;
                    det     <= S0;
                end
                SHIFT: begin
                    det     <= det_nxt;
                    run_cnt <= cnt_nxt;
                    shreg   <= {shreg[W-2:0], 1'b0};
                    bitcnt  <= bitcnt + BW'(1);
                    // Result includes a match found on the final bit.
                    if (last_bit) begin
                        match_cnt <= cnt_nxt;
                        done_id   <= grant[1];
                    end
                end
                DONE:    grant <= 2'b00;
                default: grant <= 2'b00;
            endcase
        end
    end
endmodule

// File: doc/sd_1011_scan_ctrl.md
# sd_1011_scan_ctrl

Two-requester scan controller for the 1011 sequence detector. It takes parallel words from two clients through a req/grant/done handshake and arbitrates round-robin between them. The granted word is serialised MSB-first through an internal overlapping "1011" Mealy detector, and the block returns the match count for that word. It sits between word-oriented clients and the bit-serial detection datapath, which is shared, so only one word is scanned at a time.

## Interface
- W, default 8: word width in bits; must be ≥ 4.
- CW, default 4: match counter width; must be ≥ $clog2(W/3+1).

- clk  input  1  clock; all logic updates on the rising edge.
- areset  input  1  reset; synchronous and active-high.
- req0  input  1  requester 0 wants a scan.
- data0  input  W  requester 0 word; sampled only on its grant edge.
- req1  input  1  requester 1 wants a scan.
- data1  input  W  requester 1 word; sampled only on its grant edge.
- grant  output  2  one-hot owner of the scanner; held for the whole scan; 00 when free.
- busy  output  1  high in SHIFT and DONE.
- ser_x  output  1  bit presented to the detector this cycle; 0 outside SHIFT.
- det_state  output  2  detector state (debug).
- done  output  1  one-cycle pulse; result is valid.
- done_id  output  1  requester index of the finished word; holds until the next done.
- match_cnt  output  CW  "1011" occurrences in the finished word; holds until the next done.

## Operation
- Controller FSM has three states: IDLE, SHIFT, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, any request: on that edge the block
  - picks the winner;
  - loads the winner's data into the shift register;
  - sets grant one-hot;
  - clears bit counter, running count and detector to S0;
  - moves to SHIFT.
- Arbitration:
  - only one requester high: that requester wins;
  - both high: the requester not in last_id wins;
  - last_id resets to 1, so req0 wins the first tie;
  - last_id updates on every grant.
- SHIFT:
  - ser_x = shreg[W-1];
  - the detector steps on ser_x; on a match, running count increments, saturating at 2^CW-1;
  - shreg shifts left by one and the bit counter increments;
  - after the W-th bit the FSM moves to DONE.
- DONE:
  - done=1;
  - match_cnt and done_id are loaded on the edge entering DONE;
  - grant=00 on the edge leaving DONE;
  - FSM returns to IDLE.
- Requester rules:
  - a requester drops req in the cycle it sees done;
  - a req still high in IDLE is treated as a new request;
  - req deasserting during SHIFT has no effect (the scan is not cancelled).
- Detector states: S0=00 (no prefix), S1=01 ("1"), S2=10 ("10"), S3=11 ("101").
- Detector transitions on x:
  - S0: 1→S1, 0→S0.
  - S1: 1→S1, 0→S2.
  - S2: 1→S3, 0→S0.
  - S3: 1→S1 with match, 0→S2.
- Overlap rules: overlapping matches count within a word. The detector clears at every word start, so no match spans two words.

## Timing
- Reset values: state IDLE, grant=00, busy=0, ser_x=0, det_state=00, done=0, done_id=0, match_cnt=0, last_id=1.
- areset has priority over all other behaviour at any edge, including mid-SHIFT and DONE.
  - An aborted word produces no done.
  - All outputs return to their reset values after that edge.
- Cycle sequence for one word, with accept edge k:
  - grant is high from edge k;
  - SHIFT cycles follow edges k..k+W-1;
  - DONE follows edge k+W (done high for one cycle);
  - IDLE follows edge k+W+1.
- Back-to-back throughput: a request pending during DONE is accepted at the first IDLE edge. The next grant asserts W+2 cycles after the previous grant.
- Input data needs to be stable only at the accept edge.

## Test plan
- Basic scan: after reset, req0=1, data0=8'b1011_0110 → grant=01 for 9 cycles; done at accept+8 edges; match_cnt=2, done_id=0.
- Match variants on req1:
  - data1=8'b0000_1011 → match_cnt=1;
  - data1=8'b1011_1011 → match_cnt=2;
  - data1=8'b1011_0110 followed by word 8'b1101_1011 → 2 then 2.
- Round-robin: req0 and req1 both held high from reset →
  - done_id sequence 0,1,0,1;
  - each grant separated by 10 cycles;
  - grant never 11.
- No-match words: data 8'hFF and then 8'h00 → match_cnt=0 for both; ser_x shows the MSB-first bits.
- Mid-scan reset: areset=1 for one edge during the 4th SHIFT cycle → next cycle grant=00, busy=0, match_cnt=0; no done pulse.
- Word boundary: data0=8'b0000_0101 then data1=8'b1000_0000 → both return 0 (no cross-word match). A req1 deasserted mid-scan still completes with done_id=1.
